bus_slave_ram: RTL and testbench
================================

Name: bus_slave_ram

Overview:
Word-organised RAM that is the responder (slave) end of the core's fabric bus. It accepts single read or write transfers of byte, half-word or word size (tsize encoding = funct3[1:0]), inserts a programmable number of wait states and returns right-justified read data with a one-cycle ready pulse. Transfers that are misaligned, out of range or illegal complete with err instead. It is the first memory target the RV32 core fetches from and loads from or stores to.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH_WORDS*4.
WAIT_STATES, 0, extra cycles inserted between request acceptance and ready; range 0..15.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst_n  in  1  synchronous, active-low reset.
sel  in  1  request valid; the master holds every request field stable until ready.
rd  in  1  read request.
wr  in  1  write request.
addr  in  32  byte address.
tsize  in  2  0=BYTE, 1=HALF, 2=WORD, 3=illegal.
wdata  in  32  write data, right-justified (bits [7:0] for BYTE, [15:0] for HALF).
rdata  out  32  read data, right-justified, zero-extended; valid only while ready=1 and err=0 on a read.
ready  out  1  one-cycle completion pulse.
err  out  1  asserted together with ready when the transfer faulted.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, wait counter=0, ready=0, err=0, rdata=0. RAM contents are not reset.
- FSM states:
  - IDLE: on sel & (rd|wr), capture the request and go to WAIT (WAIT_STATES>0, counter=WAIT_STATES-1) or RESP (WAIT_STATES=0).
  - WAIT: decrement the counter each cycle; at 0 go to RESP.
  - RESP: ready=1 for exactly this cycle; next state is IDLE.
- Latency: ready is high WAIT_STATES+1 cycles after the edge at which the request was sampled in IDLE. Maximum throughput is one transfer per WAIT_STATES+2 cycles.
- The master must deassert sel, or present a new request, in the cycle after ready. A request present in IDLE is accepted immediately.
- sel=0, or sel with rd=wr=0: no action, remain in IDLE.
- Error conditions, checked on captured values; each completes with ready=1, err=1, rdata=0 and no RAM write:
  - rd and wr both 1;
  - tsize=3;
  - HALF with addr[0]=1;
  - WORD with addr[1:0]!=0;
  - addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS-1].
- Word index = (addr-BASE_ADDR)>>2. Byte lane = addr[1:0].
- Write: byte-enable merge into the addressed word.
  - BYTE writes wdata[7:0] to lane addr[1:0].
  - HALF writes wdata[15:0] to lanes addr[1]*2 and addr[1]*2+1.
  - WORD writes all four lanes.
  - The RAM updates on the edge that enters RESP, so a read issued next returns the new data.
- Read: word is read and shifted right by 8*addr[1:0], then masked to 8/16/32 bits. rdata is registered and presented in the RESP cycle. Sign extension is the core's responsibility.
- rdata returns to 0 after RESP.
- Reset during WAIT or RESP: the transfer is aborted, no ready is generated afterwards, and a write not yet committed is dropped.
- Changes on the request inputs after acceptance are ignored until IDLE.

Test Plan:
- WAIT_STATES=0: write WORD 0xDEADBEEF @0x10, then read WORD @0x10 -> ready exactly 1 cycle after each request, rdata=0xDEADBEEF, err=0.
- BYTE write 0xAA @0x13, then read WORD @0x10 -> 0xAAADBEEF; read BYTE @0x13 -> 0x000000AA; read HALF @0x12 -> 0x0000AAAD.
- WAIT_STATES=3: read request -> ready high on the 4th cycle after acceptance, one cycle wide; sel held high for the whole wait causes no second acceptance.
- Errors: HALF @0x11, WORD @0x12, tsize=3, rd&wr, and addr=BASE_ADDR+4*DEPTH_WORDS -> each ready=1, err=1, rdata=0; a following read of the targeted word shows it unchanged.
- Back-to-back: new write presented the cycle after ready -> accepted in IDLE, and the next ready arrives after WAIT_STATES+1 cycles.
- Reset: rst_n=0 during WAIT of a write to @0x20 holding 0x11111111 -> ready, err and rdata all 0 next cycle; a later read of @0x20 returns 0x11111111.

Source files
------------

// File: rtl/bus_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : bus_slave_ram
// Purpose  : Word-organised RAM that responds to single read/write transfers
//            on the core fabric bus. BYTE/HALF/WORD transfers are supported.
//            A programmable number of wait states is inserted before a
//            one-cycle ready pulse. Misaligned, out-of-range or illegal
//            transfers complete with err and leave the RAM untouched.
// Ports    : clk    - clock, rising edge
//            rst_n  - synchronous active-low reset
//            sel    - request valid (held stable by the master until ready)
//            rd/wr  - read / write request
//            addr   - byte address
//            tsize  - 0=BYTE 1=HALF 2=WORD 3=illegal
//            wdata  - right-justified write data
//            rdata  - right-justified, zero-extended read data (RESP cycle)
//            ready  - one-cycle completion pulse
//            err    - fault flag, qualified by ready
// Revision : 1.0 - initial release
// ============================================================================
module bus_slave_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [1:0]  tsize,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int unsigned c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0]  c_BYTE      = 2'd0;
    localparam logic [1:0]  c_HALF      = 2'd1;
    localparam logic [1:0]  c_WORD      = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]  r_cnt;
    logic        r_rd;
    logic        r_wr;
    logic [31:0] r_addr;
    logic [1:0]  r_tsize;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic               w_idle;
    logic               w_accept;
    logic               w_enter_resp;
    logic               w_rd;
    logic               w_wr;
    logic [31:0]        w_addr;
    logic [1:0]         w_tsize;
    logic [31:0]        w_wdata;
    logic [31:0]        w_offset;
    logic [1:0]         w_lane;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_in_range;
    logic               w_err;
    logic               w_commit;
    logic [3:0]         w_be;
    logic [31:0]        w_wlanes;
    logic [31:0]        w_word;
    logic [31:0]        w_shift;
    logic [31:0]        w_rdval;

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = w_idle && sel && (rd || wr);

    // With zero wait states the RESP entry edge is the acceptance edge, so
    // the decode must look at the live bus in IDLE and at the captured
    // request everywhere else.
    assign w_rd    = w_idle ? rd    : r_rd;
    assign w_wr    = w_idle ? wr    : r_wr;
    assign w_addr  = w_idle ? addr  : r_addr;
    assign w_tsize = w_idle ? tsize : r_tsize;
    assign w_wdata = w_idle ? wdata : r_wdata;

    // BASE_ADDR is aligned to the RAM size, so the low offset bits equal the
    // address byte lane, and an address below BASE wraps to a huge offset
    // that fails the range check.
    assign w_offset   = w_addr - BASE_ADDR;
    assign w_lane     = w_offset[1:0];
    assign w_idx      = w_offset[c_IDX_W+1:2];
    assign w_in_range = ({2'b00, w_offset[31:2]} < DEPTH_WORDS);

    assign w_err = (w_rd && w_wr)
                || (w_tsize == 2'd3)
                || ((w_tsize == c_HALF) && w_lane[0])
                || ((w_tsize == c_WORD) && (w_lane != 2'd0))
                || !w_in_range;

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);
    assign w_commit     = w_enter_resp && w_wr && !w_err;

    // Byte enables and lane-replicated write data
    always_comb begin
        w_be     = 4'b1111;
        w_wlanes = w_wdata;
        case (w_tsize)
            c_BYTE: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{w_wdata[7:0]}};
            end
            c_HALF: begin
                w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_be     = 4'b1111;
                w_wlanes = w_wdata;
            end
        endcase
    end

    // Read path: shift addressed lane down, then mask to transfer size
    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {w_lane, 3'b000};

    always_comb begin
        w_rdval = w_shift;
        case (w_tsize)
            c_BYTE:  w_rdval = {24'd0, w_shift[7:0]};
            c_HALF:  w_rdval = {16'd0, w_shift[15:0]};
            default: w_rdval = w_shift;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= 4'd0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= 32'd0;
            r_tsize <= 2'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rd    <= rd;
                r_wr    <= wr;
                r_addr  <= addr;
                r_tsize <= tsize;
                r_wdata <= wdata;
                r_cnt   <= c_WAIT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Response registers are non-zero only during the RESP cycle
            r_err   <= w_enter_resp && w_err;
            r_rdata <= (w_enter_resp && w_rd && !w_err) ? w_rdval : 32'd0;
        end
    end

    // RAM contents are not reset; a reset on the commit edge drops the write
    always_ff @(posedge clk) begin
        if (rst_n && w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wlanes[8*b +: 8];
                end
            end
        end
    end

    assign ready = (r_state == S_RESP);
    assign err   = r_err;
    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_slave_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_slave_ram
// Purpose  : Self-checking bench for bus_slave_ram. Two instances are used:
//            one with no wait states at base 0, one with three wait states
//            at base 0x1000_0000. Transfers come from a vector table; the
//            expected response is queued when a request is driven and
//            compared when ready is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_slave_ram;

    logic        clk;
    logic        rst_n;
    logic        sel0;
    logic        sel3;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  tsize;
    logic [31:0] wdata;
    logic [31:0] rdata0;
    logic [31:0] rdata3;
    logic        ready0;
    logic        ready3;
    logic        err0;
    logic        err3;

    int checks;
    int errors;

    typedef struct {
        bit          inst;
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [1:0]  tsize;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    typedef struct {
        bit          inst;
        bit          chk_rd;
        logic [31:0] rdata;
        bit          err;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];

    bus_slave_ram #(
        .DEPTH_WORDS (16),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_STATES (0)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel0),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .tsize (tsize),
        .wdata (wdata),
        .rdata (rdata0),
        .ready (ready0),
        .err   (err0)
    );

    bus_slave_ram #(
        .DEPTH_WORDS (16),
        .BASE_ADDR   (32'h1000_0000),
        .WAIT_STATES (3)
    ) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .sel   (sel3),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .tsize (tsize),
        .wdata (wdata),
        .rdata (rdata3),
        .ready (ready3),
        .err   (err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit inst, input bit r, input bit w,
                                input logic [31:0] a, input logic [1:0] ts,
                                input logic [31:0] wd, input logic [31:0] er,
                                input bit ee);
        vec_t v;
        v.inst = inst; v.rd = r; v.wr = w; v.addr = a; v.tsize = ts;
        v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // Drive one transfer, queue its expectation, check latency and pulse width.
    // Called at #1 after a rising edge with the target in IDLE.
    task automatic xfer(input vec_t v);
        int   n;
        logic rdy;
        sb_t  e;
        sel0  = (v.inst == 1'b0);
        sel3  = (v.inst == 1'b1);
        rd    = v.rd;
        wr    = v.wr;
        addr  = v.addr;
        tsize = v.tsize;
        wdata = v.wdata;
        e.inst   = v.inst;
        e.chk_rd = v.rd || v.exp_err;
        e.rdata  = v.exp_rdata;
        e.err    = v.exp_err;
        sb.push_back(e);
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            rdy = v.inst ? ready3 : ready0;
        end
        chk(v.inst ? "latency_ws3" : "latency_ws0", 32'(n), v.inst ? 32'd4 : 32'd1);
        // sel stays high through the ready cycle; it must be ignored there
        @(posedge clk);
        #1;
        chk("ready_width", {31'd0, ready0 | ready3}, 32'd0);
        sel0 = 1'b0;
        sel3 = 1'b0;
        rd   = 1'b0;
        wr   = 1'b0;
    endtask

    // Scoreboard monitor: sample away from the rising edge
    initial begin
        logic        rdy;
        logic        e_err;
        logic [31:0] e_rdata;
        sb_t         exp_e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                rdy     = (i == 0) ? ready0 : ready3;
                e_err   = (i == 0) ? err0   : err3;
                e_rdata = (i == 0) ? rdata0 : rdata3;
                if (rdy === 1'b1) begin
                    if (sb.size() == 0 || sb[0].inst != 1'(i)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready: inst %0d got ready 1 expected 0 at %0t", i, $time);
                    end else begin
                        exp_e = sb.pop_front();
                        chk("err", {31'd0, e_err}, {31'd0, exp_e.err});
                        if (exp_e.chk_rd) begin
                            chk("rdata", e_rdata, exp_e.rdata);
                        end
                    end
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        sel0 = 1'b0; sel3 = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = 32'd0; tsize = 2'd0; wdata = 32'd0;

        // inst 0: WAIT_STATES=0, base 0, 16 words
        vecs.push_back(mk(0, 0, 1, 32'h00, 2'd2, 32'h0102_0304, 32'h0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h10, 2'd2, 32'hDEAD_BEEF, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h10, 2'd2, 32'h0,         32'hDEAD_BEEF, 0));
        vecs.push_back(mk(0, 0, 1, 32'h13, 2'd0, 32'h0000_00AA, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h10, 2'd2, 32'h0,         32'hAAAD_BEEF, 0));
        vecs.push_back(mk(0, 1, 0, 32'h13, 2'd0, 32'h0,         32'h0000_00AA, 0));
        vecs.push_back(mk(0, 1, 0, 32'h12, 2'd1, 32'h0,         32'h0000_AAAD, 0));
        vecs.push_back(mk(0, 1, 0, 32'h11, 2'd0, 32'h0,         32'h0000_00BE, 0));
        vecs.push_back(mk(0, 0, 1, 32'h12, 2'd1, 32'hFFFF_1234, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h10, 2'd2, 32'h0,         32'h1234_BEEF, 0));
        vecs.push_back(mk(0, 1, 0, 32'h10, 2'd1, 32'h0,         32'h0000_BEEF, 0));
        // faults: none may touch the RAM
        vecs.push_back(mk(0, 0, 1, 32'h11, 2'd1, 32'hFFFF_FFFF, 32'h0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h12, 2'd2, 32'hFFFF_FFFF, 32'h0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h10, 2'd3, 32'hFFFF_FFFF, 32'h0, 1));
        vecs.push_back(mk(0, 1, 1, 32'h10, 2'd2, 32'hFFFF_FFFF, 32'h0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h13, 2'd1, 32'h0,         32'h0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h10, 2'd3, 32'h0,         32'h0, 1));
        vecs.push_back(mk(0, 0, 1, 32'h40, 2'd2, 32'hFFFF_FFFF, 32'h0, 1));
        vecs.push_back(mk(0, 1, 0, 32'h10, 2'd2, 32'h0,         32'h1234_BEEF, 0));
        vecs.push_back(mk(0, 1, 0, 32'h00, 2'd2, 32'h0,         32'h0102_0304, 0));
        // top word boundary
        vecs.push_back(mk(0, 0, 1, 32'h3C, 2'd2, 32'hCAFE_F00D, 32'h0, 0));
        vecs.push_back(mk(0, 1, 0, 32'h3C, 2'd2, 32'h0,         32'hCAFE_F00D, 0));
        vecs.push_back(mk(0, 1, 0, 32'h3F, 2'd0, 32'h0,         32'h0000_00CA, 0));
        vecs.push_back(mk(0, 1, 0, 32'h40, 2'd2, 32'h0,         32'h0, 1));
        // inst 1: WAIT_STATES=3, base 0x1000_0000, 16 words
        vecs.push_back(mk(1, 0, 1, 32'h1000_0020, 2'd2, 32'h1111_1111, 32'h0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h1000_0020, 2'd2, 32'h0, 32'h1111_1111, 0));
        vecs.push_back(mk(1, 0, 1, 32'h1000_0024, 2'd2, 32'h0, 32'h0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h1000_0025, 2'd0, 32'h0000_0055, 32'h0, 0));
        vecs.push_back(mk(1, 1, 0, 32'h1000_0024, 2'd2, 32'h0, 32'h0000_5500, 0));
        vecs.push_back(mk(1, 1, 0, 32'h1000_0024, 2'd1, 32'h0, 32'h0000_5500, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0FFF_FFFC, 2'd2, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 0, 1, 32'h1000_0040, 2'd2, 32'hFFFF_FFFF, 32'h0, 1));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready0", {31'd0, ready0}, 32'd0);
        chk("rst_err0",   {31'd0, err0},   32'd0);
        chk("rst_rdata0", rdata0,          32'd0);
        chk("rst_ready3", {31'd0, ready3}, 32'd0);
        chk("rst_err3",   {31'd0, err3},   32'd0);
        chk("rst_rdata3", rdata3,          32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back: each request is presented the cycle after ready
        for (int i = 0; i < vecs.size(); i++) begin
            xfer(vecs[i]);
        end

        // Reset during WAIT of a write to 0x20 (holds 0x11111111)
        sel3  = 1'b1;
        rd    = 1'b0;
        wr    = 1'b1;
        addr  = 32'h1000_0020;
        tsize = 2'd2;
        wdata = 32'h2222_2222;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("wait_no_ready", {31'd0, ready3}, 32'd0);
        rst_n = 1'b0;
        sel3  = 1'b0;
        wr    = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready", {31'd0, ready3}, 32'd0);
        chk("abort_err",   {31'd0, err3},   32'd0);
        chk("abort_rdata", rdata3,          32'd0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        xfer(mk(1, 1, 0, 32'h1000_0020, 2'd2, 32'h0, 32'h1111_1111, 0));

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
